// File: rtl/fullchip_inst_seq_pkg.sv
// Shared constants for the fullchip instruction sequencer: inst[16:0] field
// positions, counter width and the sequencer state encoding.
package fullchip_inst_seq_pkg;

   localparam int INST_W        = 17;
   localparam int INST_OFIFO_RD = 16;
   localparam int INST_QK_ADDR  = 12;
   localparam int INST_P_ADDR   = 8;
   localparam int INST_EXECUTE  = 7;
   localparam int INST_LOAD     = 6;
   localparam int INST_QMEM_RD  = 5;
   localparam int INST_QMEM_WR  = 4;
   localparam int INST_KMEM_RD  = 3;
   localparam int INST_KMEM_WR  = 2;
   localparam int INST_PMEM_RD  = 1;
   localparam int INST_PMEM_WR  = 0;

   localparam int ADDR_W = 4;
   localparam int CNT_W  = 8;

   typedef enum logic [3:0] {
      S_IDLE, S_QWR, S_KWR, S_GAP0, S_LOAD, S_GAP1,
      S_EXEC, S_GAP2, S_DRAIN, S_GAP3, S_PRD, S_DONE
   } state_t;

   // Places a 4-bit address into an otherwise empty instruction word.
   function automatic logic [INST_W-1:0] addr_field(input int lsb, input logic [ADDR_W-1:0] a);
      return INST_W'(a) << lsb;
   endfunction

endpackage

// File: rtl/fullchip_inst_seq_phase_cnt.sv
// Loadable up-counter: ld restarts at 0 with a new length, en advances,
// last flags the final count of the loaded length.
module fullchip_inst_seq_phase_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic [W-1:0] len,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         last
);

   logic [W-1:0] lim;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         lim <= '0;
      end else if (ld) begin
         cnt <= '0;
         lim <= len - 1'b1;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign last = (cnt == lim);

endmodule

// File: rtl/fullchip_inst_seq.sv
// Instruction sequencer for fullchip: streams Q then K vectors into the
// Q/K memories, then plays the fixed load/execute/drain/readback program.
module fullchip_inst_seq
   import fullchip_inst_seq_pkg::*;
#(
   parameter int bw          = 8,
   parameter int pr          = 8,
   parameter int col         = 8,
   parameter int total_cycle = 8,
   parameter int gap         = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic                in_valid,
   input  logic [pr*bw-1:0]    in_data,
   output logic                in_ready,
   output logic [pr*bw-1:0]    mem_in,
   output logic [INST_W-1:0]   inst,
   output logic                busy,
   output logic                done
);

   localparam logic [CNT_W-1:0] LEN_Q   = CNT_W'(total_cycle);
   localparam logic [CNT_W-1:0] LEN_K   = CNT_W'(col);
   localparam logic [CNT_W-1:0] LEN_LD  = CNT_W'(col + 2);
   localparam logic [CNT_W-1:0] LEN_G0  = CNT_W'(2);
   localparam logic [CNT_W-1:0] LEN_GAP = CNT_W'(gap);

   state_t              st, st_n;
   logic [INST_W-1:0]   inst_n;
   logic                rdy_n, busy_n, done_n, cap;
   logic                ld, en, last, acc;
   logic [CNT_W-1:0]    len, cnt;
   logic [ADDR_W-1:0]   ld_addr;

   fullchip_inst_seq_phase_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (reset),
      .ld    (ld),
      .len   (len),
      .en    (en),
      .cnt   (cnt),
      .last  (last)
   );

   assign acc     = in_valid & in_ready;
   assign ld_addr = cnt[ADDR_W-1:0] - 1'b1;

   // State/counter run one cycle ahead: each edge registers the word for the
   // cycle the current state/count describes.
   always_comb begin
      st_n   = st;
      inst_n = '0;
      rdy_n  = 1'b0;
      busy_n = busy;
      done_n = 1'b0;
      cap    = 1'b0;
      ld     = 1'b0;
      len    = LEN_GAP;
      en     = 1'b1;
      case (st)
         S_IDLE: begin
            en = 1'b0;
            if (start) begin
               st_n   = S_QWR;
               ld     = 1'b1;
               len    = LEN_Q;
               rdy_n  = 1'b1;
               busy_n = 1'b1;
            end
         end
         S_QWR: begin
            rdy_n = 1'b1;
            en    = acc;
            if (acc) begin
               cap    = 1'b1;
               inst_n = addr_field(INST_QK_ADDR, cnt[ADDR_W-1:0]);
               inst_n[INST_QMEM_WR] = 1'b1;
               if (last) begin
                  st_n = S_KWR;
                  ld   = 1'b1;
                  len  = LEN_K;
               end
            end
         end
         S_KWR: begin
            rdy_n = 1'b1;
            en    = acc;
            if (acc) begin
               cap    = 1'b1;
               inst_n = addr_field(INST_QK_ADDR, cnt[ADDR_W-1:0]);
               inst_n[INST_KMEM_WR] = 1'b1;
               if (last) begin
                  st_n  = S_GAP0;
                  ld    = 1'b1;
                  len   = LEN_G0;
                  rdy_n = 1'b0;
               end
            end
         end
         S_GAP0: if (last) begin st_n = S_LOAD; ld = 1'b1; len = LEN_LD; end
         S_LOAD: begin
            // first and last load cycles carry no K read
            if (cnt != '0 && cnt <= LEN_K) begin
               inst_n = addr_field(INST_QK_ADDR, ld_addr);
               inst_n[INST_KMEM_RD] = 1'b1;
            end
            inst_n[INST_LOAD] = 1'b1;
            if (last) begin st_n = S_GAP1; ld = 1'b1; end
         end
         S_GAP1: if (last) begin st_n = S_EXEC; ld = 1'b1; len = LEN_Q; end
         S_EXEC: begin
            inst_n = addr_field(INST_QK_ADDR, cnt[ADDR_W-1:0]);
            inst_n[INST_EXECUTE] = 1'b1;
            inst_n[INST_QMEM_RD] = 1'b1;
            if (last) begin st_n = S_GAP2; ld = 1'b1; end
         end
         S_GAP2: if (last) begin st_n = S_DRAIN; ld = 1'b1; len = LEN_Q; end
         S_DRAIN: begin
            inst_n = addr_field(INST_P_ADDR, cnt[ADDR_W-1:0]);
            inst_n[INST_OFIFO_RD] = 1'b1;
            inst_n[INST_PMEM_WR]  = 1'b1;
            if (last) begin st_n = S_GAP3; ld = 1'b1; end
         end
         S_GAP3: if (last) begin st_n = S_PRD; ld = 1'b1; len = LEN_Q; end
         S_PRD: begin
            inst_n = addr_field(INST_P_ADDR, cnt[ADDR_W-1:0]);
            inst_n[INST_PMEM_RD] = 1'b1;
            if (last) st_n = S_DONE;
         end
         S_DONE: begin
            st_n   = S_IDLE;
            done_n = 1'b1;
            busy_n = 1'b0;
         end
         default: st_n = S_IDLE;
      endcase
      if (abort) begin
         st_n   = S_IDLE;
         inst_n = '0;
         rdy_n  = 1'b0;
         busy_n = 1'b0;
         done_n = 1'b0;
         cap    = 1'b0;
         ld     = 1'b0;
         en     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st       <= S_IDLE;
         inst     <= '0;
         mem_in   <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         st       <= st_n;
         inst     <= inst_n;
         in_ready <= rdy_n;
         busy     <= busy_n;
         done     <= done_n;
         if (cap) mem_in <= in_data;
      end
   end

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// Randomized bench for fullchip_inst_seq: a per-cycle expected trace is
// built from the phase program and compared against every DUT output.
module tb_fullchip_inst_seq;

   localparam int TC  = 8;
   localparam int COL = 8;
   localparam int GAP = 10;
   localparam int DW  = 64;

   typedef struct {
      logic [16:0]   inst;
      logic          rdy;
      logic          busy;
      logic          done;
      logic [DW-1:0] mem;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, start, abort, in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [DW-1:0] mem_in;
   logic [16:0]   inst;
   logic          busy, done;

   int n_run = 0, n_fail = 0, cur = 0;

   exp_t          ex[$];
   bit            dv[$];
   bit            sr[$];
   logic [DW-1:0] dd[$];
   logic [DW-1:0] mem_m;

   always #5 clk = ~clk;

   fullchip_inst_seq #(
      .bw(8), .pr(8), .col(COL), .total_cycle(TC), .gap(GAP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mem_in   (mem_in),
      .inst     (inst),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cur, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom};
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(1));
   endfunction

   // One expected cycle; a stray start is only thrown in while the run is busy.
   task automatic push_e(input logic [16:0] i, input logic r, input logic b, input logic d,
                         input bit v, input logic [DW-1:0] dat);
      exp_t e;
      e.inst = i; e.rdy = r; e.busy = b; e.done = d; e.mem = mem_m;
      ex.push_back(e);
      dv.push_back(v);
      dd.push_back(dat);
      sr.push_back(b && ($urandom_range(7) == 0));
   endtask

   // mode 0: in_valid always high, 2: 3-cycle drop at Q beat 4, else random valid
   task automatic build(input int mode);
      logic [DW-1:0] bt [TC+COL];
      logic [16:0]   prev, w;
      int            b, stall;
      ex.delete(); dv.delete(); dd.delete(); sr.delete();
      push_e('0, 0, 0, 0, 0, '0);
      foreach (bt[i]) bt[i] = rnd();
      b = 0; prev = '0; stall = 0;
      while (b < TC + COL) begin
         bit v;
         if (mode == 0) v = 1'b1;
         else if (mode == 2) begin
            v = !(b == 4 && stall < 3);
            if (!v) stall++;
         end else v = ($urandom_range(3) != 0);
         push_e(prev, 1, 1, 0, v, v ? bt[b] : rnd());
         prev = '0;
         if (v) begin
            if (b < TC) begin prev[4] = 1'b1; prev[15:12] = 4'(b); end
            else begin prev[2] = 1'b1; prev[15:12] = 4'(b - TC); end
            mem_m = bt[b];
            b++;
         end
      end
      push_e(prev, 0, 1, 0, rb(), rnd());
      for (int i = 0; i < 2; i++) push_e('0, 0, 1, 0, rb(), rnd());
      for (int i = 0; i < COL + 2; i++) begin
         w = '0; w[6] = 1'b1;
         if (i >= 1 && i <= COL) begin w[3] = 1'b1; w[15:12] = 4'(i - 1); end
         push_e(w, 0, 1, 0, rb(), rnd());
      end
      for (int i = 0; i < GAP; i++) push_e('0, 0, 1, 0, rb(), rnd());
      for (int i = 0; i < TC; i++) begin
         w = '0; w[7] = 1'b1; w[5] = 1'b1; w[15:12] = 4'(i);
         push_e(w, 0, 1, 0, rb(), rnd());
      end
      for (int i = 0; i < GAP; i++) push_e('0, 0, 1, 0, rb(), rnd());
      for (int i = 0; i < TC; i++) begin
         w = '0; w[16] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(i);
         push_e(w, 0, 1, 0, rb(), rnd());
      end
      for (int i = 0; i < GAP; i++) push_e('0, 0, 1, 0, rb(), rnd());
      for (int i = 0; i < TC; i++) begin
         w = '0; w[1] = 1'b1; w[11:8] = 4'(i);
         push_e(w, 0, 1, 0, rb(), rnd());
      end
      push_e('0, 0, 0, 1, rb(), rnd());
      for (int i = 0; i < 2; i++) push_e('0, 0, 0, 0, rb(), rnd());
   endtask

   // mode 3: abort at DRAIN addr 3, mode 4: reset at EXEC addr 2
   task automatic run(input int mode);
      int ab_at, rs_at, done_c;
      ab_at = -1; rs_at = -1; done_c = -1;
      build((mode == 3 || mode == 4) ? 1 : mode);
      for (int c = 1; c < ex.size(); c++) begin
         if (mode == 3 && ab_at < 0 && ex[c].inst[16] && ex[c].inst[11:8] == 4'd3) ab_at = c;
         if (mode == 4 && rs_at < 0 && ex[c].inst[7] && ex[c].inst[15:12] == 4'd2) rs_at = c;
      end
      if (ab_at > 0) begin
         while (ex.size() > ab_at + 1) begin
            void'(ex.pop_back()); void'(dv.pop_back()); void'(dd.pop_back()); void'(sr.pop_back());
         end
         for (int i = 0; i < 3; i++) push_e('0, 0, 0, 0, rb(), rnd());
      end
      start = 1'b1; abort = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < ex.size(); c++) begin
         cur = c;
         chk("inst",     inst,     ex[c].inst);
         chk("in_ready", in_ready, ex[c].rdy);
         chk("busy",     busy,     ex[c].busy);
         chk("done",     done,     ex[c].done);
         chk("mem_in",   mem_in,   ex[c].mem);
         if (done) done_c = c;
         if (c == rs_at) begin
            reset = 1'b0; #1;
            chk("rst_inst", inst, '0);
            chk("rst_busy", busy, '0);
            chk("rst_rdy",  in_ready, '0);
            chk("rst_done", done, '0);
            chk("rst_mem",  mem_in, '0);
            @(posedge clk); #1;
            chk("rst_hold_busy", busy, '0);
            #3 reset = 1'b1;
            @(posedge clk); #1;
            chk("post_rst_inst", inst, '0);
            chk("post_rst_busy", busy, '0);
            mem_m = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
            return;
         end
         in_valid = dv[c];
         in_data  = dd[c];
         start    = sr[c];
         abort    = (c == ab_at);
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      if (mode == 0) chk("done_lat", done_c, 84);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cur);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; mem_m = '0;
      #12;
      chk("rst0_inst", inst, '0);
      chk("rst0_rdy",  in_ready, '0);
      chk("rst0_busy", busy, '0);
      chk("rst0_done", done, '0);
      chk("rst0_mem",  mem_in, '0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      run(0);
      run(2);
      run(1);
      run(3);
      run(1);
      run(4);
      run(1);
      // start together with abort in IDLE must not launch
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", busy, '0);
      chk("sa_rdy",  in_ready, '0);
      chk("sa_inst", inst, '0);
      @(posedge clk); #1;
      chk("sa_busy2", busy, '0);
      run(0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
